// File: rtl/fifo_packetizer.sv
// Drains a first-word-fall-through FIFO into a packet buffer and emits framed
// packets (SYNC, LEN, payload, CHK) on a valid/ready byte stream.
module fifo_packetizer #(
    parameter int         MAX_LEN   = 64,
    parameter int         TIMEOUT   = 255,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       fifo_pop,
    input  logic [7:0] fifo_data,
    input  logic       fifo_nempty,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       busy
);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);
    localparam logic [15:0]   TMO     = 16'(TIMEOUT);

    typedef enum logic [2:0] {S_COLLECT, S_SYNC, S_LEN, S_PAYLOAD, S_CHK} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] idx_reg;
    logic [15:0]   timer_reg;
    logic [7:0]    sum_reg;
    logic          run_reg;
    logic [7:0]    buf_mem [MAX_LEN];

    logic       flush;
    logic       accept;
    logic [7:0] chk;

    assign flush  = (count_reg == MAX_CNT) || ((count_reg != '0) && (timer_reg == TMO));
    assign accept = out_valid && out_ready;
    // Checksum makes LEN + payload + CHK sum to zero modulo 256.
    assign chk    = 8'(8'd0 - (8'(count_reg) + sum_reg));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_COLLECT: if (flush) state_next = S_SYNC;
            S_SYNC:    if (accept) state_next = S_LEN;
            S_LEN:     if (accept) state_next = S_PAYLOAD;
            S_PAYLOAD: if (accept && !(idx_reg < count_reg)) state_next = S_CHK;
            S_CHK:     if (accept) state_next = S_COLLECT;
            default:   state_next = S_COLLECT;
        endcase
    end

    always_comb begin
        fifo_pop = run_reg && (state_reg == S_COLLECT) && fifo_nempty && !flush;
    end

    // Buffer storage carries no reset so it can map onto RAM; count gates reads.
    always_ff @(posedge clk) begin
        if (fifo_pop) begin
            buf_mem[count_reg[AW-1:0]] <= fifo_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            count_reg <= '0;
            idx_reg   <= '0;
            timer_reg <= '0;
            sum_reg   <= 8'h00;
            run_reg   <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            case (state_reg)
                S_COLLECT: begin
                    if (fifo_pop) begin
                        count_reg <= count_reg + 1'b1;
                        sum_reg   <= sum_reg + fifo_data;
                    end
                    if (fifo_pop && (count_reg == '0)) begin
                        timer_reg <= '0;
                    end else if ((count_reg != '0) && !flush && (timer_reg != TMO)) begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                    if (flush) begin
                        out_valid <= 1'b1;
                        out_data  <= SYNC_BYTE;
                        busy      <= 1'b1;
                    end
                end
                S_SYNC: begin
                    if (accept) out_data <= 8'(count_reg);
                end
                // idx is zero here, so LEN and PAYLOAD share one buffer read port.
                S_LEN: begin
                    if (accept) begin
                        out_data <= buf_mem[idx_reg[AW-1:0]];
                        idx_reg  <= idx_reg + 1'b1;
                    end
                end
                S_PAYLOAD: begin
                    if (accept) begin
                        if (idx_reg < count_reg) begin
                            out_data <= buf_mem[idx_reg[AW-1:0]];
                            idx_reg  <= idx_reg + 1'b1;
                        end else begin
                            out_data <= chk;
                            out_last <= 1'b1;
                        end
                    end
                end
                S_CHK: begin
                    if (accept) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        count_reg <= '0;
                        idx_reg   <= '0;
                        timer_reg <= '0;
                        sum_reg   <= 8'h00;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
